ether_rx_reader: RTL and testbench

- Host-side consumer that sits directly downstream of the MII receive buffer block. It drives that block's command port (cs/cmd) and tracks its toggle-style ready.
- On each received-frame notification it fetches the frame size (GETSIZE = 1), then reads each 32-bit word (GETDATA = 2).
- It presents the words as a valid/ready stream with a last flag toward the host packet logic.
- Runs on the same clock as the receive block. That block acts on negedge; this block acts on posedge.

---
 rtl/ether_rx_reader.sv | 139 +++++++++++++
 tb/tb_ether_rx_reader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ether_rx_reader.sv
// Reads frames out of the MII receive buffer: GETSIZE, then one GETDATA per word, streamed with a last flag.
// Latency: one word in flight; each word costs cs assert + upstream response + one OUT handshake cycle.
// Backpressure: rdr_rdy low holds the current word and no further GETDATA is issued until it is accepted.
module ether_rx_reader #(
    parameter int         MAX_WORDS   = 376,
    parameter int         TIMEOUT     = 64,
    parameter logic [3:0] CMD_GETSIZE = 4'd1,
    parameter logic [3:0] CMD_GETDATA = 4'd2
) (
    input  logic        rdr_clk,
    input  logic        rdr_rst,
    input  logic        rdr_en,
    output logic        erx_cs,
    output logic [3:0]  erx_cmd,
    input  logic        erx_ready,
    input  logic [31:0] erx_data,
    output logic [31:0] rdr_data,
    output logic        rdr_valid,
    input  logic        rdr_rdy,
    output logic        rdr_last,
    output logic [8:0]  rdr_words,
    output logic        rdr_trunc,
    output logic        rdr_err,
    output logic        rdr_busy
);

    localparam int         TW    = $clog2(TIMEOUT + 1);
    localparam logic [8:0] MAX_W = 9'(MAX_WORDS);

    typedef enum logic [2:0] {SYNC, IDLE, SIZE_REQ, DATA_REQ, OUT} state_t;

    state_t          state;
    logic            ready_seen;
    logic [8:0]      word_cnt;
    logic [8:0]      n_words;
    logic [TW-1:0]   tmo_cnt;

    logic            tog;
    logic [8:0]      size_w;
    logic [8:0]      n_next;
    logic            tmo_hit;

    assign tog      = (erx_ready != ready_seen);
    assign size_w   = erx_data[8:0];
    assign n_next   = (size_w > MAX_W) ? MAX_W : size_w;
    assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT - 1));
    assign rdr_busy = (state != IDLE);

    always_ff @(posedge rdr_clk or posedge rdr_rst) begin
        if (rdr_rst) begin
            state      <= SYNC;
            ready_seen <= 1'b0;
            word_cnt   <= '0;
            n_words    <= '0;
            tmo_cnt    <= '0;
            erx_cs     <= 1'b0;
            erx_cmd    <= 4'd0;
            rdr_data   <= '0;
            rdr_valid  <= 1'b0;
            rdr_last   <= 1'b0;
            rdr_words  <= '0;
            rdr_trunc  <= 1'b0;
            rdr_err    <= 1'b0;
        end else begin
            rdr_err <= 1'b0;
            case (state)
                SYNC: begin
                    ready_seen <= erx_ready;
                    state      <= IDLE;
                end
                IDLE: begin
                    if (tog) begin
                        ready_seen <= erx_ready;
                        if (rdr_en) begin
                            state   <= SIZE_REQ;
                            erx_cs  <= 1'b1;
                            erx_cmd <= CMD_GETSIZE;
                            tmo_cnt <= '0;
                        end
                    end
                end
                SIZE_REQ: begin
                    if (tog) begin
                        ready_seen <= erx_ready;
                        erx_cs     <= 1'b0;
                        erx_cmd    <= 4'd0;
                        rdr_words  <= size_w;
                        rdr_trunc  <= (size_w > MAX_W);
                        n_words    <= n_next;
                        word_cnt   <= '0;
                        state      <= (n_next == 9'd0) ? IDLE : DATA_REQ;
                    end else if (tmo_hit) begin
                        erx_cs  <= 1'b0;
                        erx_cmd <= 4'd0;
                        rdr_err <= 1'b1;
                        state   <= SYNC;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                DATA_REQ: begin
                    // cs is always low for a cycle between commands so each strobe is a fresh request
                    if (!erx_cs) begin
                        erx_cs  <= 1'b1;
                        erx_cmd <= CMD_GETDATA;
                        tmo_cnt <= '0;
                    end else if (tog) begin
                        ready_seen <= erx_ready;
                        erx_cs     <= 1'b0;
                        erx_cmd    <= 4'd0;
                        rdr_data   <= erx_data;
                        rdr_valid  <= 1'b1;
                        rdr_last   <= (word_cnt == n_words - 9'd1);
                        state      <= OUT;
                    end else if (tmo_hit) begin
                        erx_cs    <= 1'b0;
                        erx_cmd   <= 4'd0;
                        rdr_err   <= 1'b1;
                        rdr_valid <= 1'b0;
                        state     <= SYNC;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                OUT: begin
                    // a toggle seen here is left pending; it answers the next command
                    if (rdr_rdy) begin
                        rdr_valid <= 1'b0;
                        rdr_last  <= 1'b0;
                        word_cnt  <= word_cnt + 9'd1;
                        state     <= rdr_last ? IDLE : DATA_REQ;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_ether_rx_reader.sv
// Bench for ether_rx_reader: negedge responder modelling the receive buffer, scoreboard on the stream side.
module tb_ether_rx_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdr_en = 1'b1;
    logic        erx_cs;
    logic [3:0]  erx_cmd;
    logic        erx_ready = 1'b1;
    logic [31:0] erx_data = '0;
    logic [31:0] rdr_data;
    logic        rdr_valid;
    logic        rdr_rdy = 1'b1;
    logic        rdr_last;
    logic [8:0]  rdr_words;
    logic        rdr_trunc;
    logic        rdr_err;
    logic        rdr_busy;

    ether_rx_reader dut (
        .rdr_clk   (clk),
        .rdr_rst   (rst),
        .rdr_en    (rdr_en),
        .erx_cs    (erx_cs),
        .erx_cmd   (erx_cmd),
        .erx_ready (erx_ready),
        .erx_data  (erx_data),
        .rdr_data  (rdr_data),
        .rdr_valid (rdr_valid),
        .rdr_rdy   (rdr_rdy),
        .rdr_last  (rdr_last),
        .rdr_words (rdr_words),
        .rdr_trunc (rdr_trunc),
        .rdr_err   (rdr_err),
        .rdr_busy  (rdr_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Responder: frame notification and command answers, all on negedge like the real buffer.
    int          fr_size = 0;
    logic [31:0] fr_base = '0;
    int          ptr = 0;
    int          resp_lat = 1;
    int          lat_cnt = 0;
    bit          answered = 0;
    bit          mute_data = 0;
    bit          notify_req = 0;

    always @(negedge clk) begin
        if (notify_req) begin
            erx_ready  = ~erx_ready;
            notify_req = 0;
        end
        if (!erx_cs) begin
            answered = 0;
            lat_cnt  = 0;
        end else if (!answered) begin
            lat_cnt++;
            if (lat_cnt >= resp_lat) begin
                if (erx_cmd == 4'd1) begin
                    erx_data  = 32'(fr_size);
                    ptr       = 0;
                    erx_ready = ~erx_ready;
                    answered  = 1;
                end else if (erx_cmd == 4'd2 && !mute_data) begin
                    erx_data  = fr_base + 32'(ptr) + 32'd1;
                    ptr++;
                    erx_ready = ~erx_ready;
                    answered  = 1;
                end
            end
        end
    end

    // Stream scoreboard and protocol checks.
    typedef struct {
        logic [31:0] d;
        logic        l;
    } beat_t;
    beat_t       exp_q[$];
    int          beats = 0;
    bit          hold_vld = 0;
    logic [31:0] hold_dat = '0;
    logic        hold_last = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (rdr_valid && hold_vld) begin
                chk("hold_data", rdr_data, hold_dat);
                chk("hold_last", 32'(rdr_last), 32'(hold_last));
            end
            if (erx_cs && rdr_valid) begin
                checks++;
                errors++;
                $display("FAIL cs_during_out: erx_cs=1 while word pending at %0t", $time);
            end
            if (rdr_valid && rdr_rdy) begin
                beats++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: data 0x%0h with empty scoreboard", rdr_data);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", rdr_data, e.d);
                    chk("beat_last", 32'(rdr_last), 32'(e.l));
                end
            end
            hold_vld  = rdr_valid && !rdr_rdy;
            hold_dat  = rdr_data;
            hold_last = rdr_last;
        end
    end

    // Consumer: stalls a chosen beat for a number of cycles.
    int stall_beat = 0;
    int stall_left = 0;

    always @(posedge clk) begin
        #1;
        if (stall_left > 0 && rdr_valid && beats == stall_beat - 1) begin
            rdr_rdy = 1'b0;
            stall_left--;
        end else begin
            rdr_rdy = 1'b1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          size;
        logic [31:0] base;
        int          lat;
        int          sbeat;
        int          scyc;
        int          exp_n;
        bit          exp_trunc;
    } vec_t;
    vec_t vecs[6];

    task automatic wait_busy(input bit level, input int limit, input string name);
        int t;
        for (t = 0; t < limit && rdr_busy != level; t++) @(negedge clk);
        chk(name, 32'(rdr_busy), 32'(level));
    endtask

    task automatic run_frame(input vec_t v);
        int b0;
        fr_size    = v.size;
        fr_base    = v.base;
        resp_lat   = v.lat;
        stall_beat = v.sbeat;
        stall_left = v.scyc;
        for (int i = 0; i < v.exp_n; i++) begin
            beat_t e;
            e.d = v.base + 32'(i) + 32'd1;
            e.l = (i == v.exp_n - 1);
            exp_q.push_back(e);
        end
        b0 = beats;
        @(negedge clk);
        notify_req = 1;
        wait_busy(1'b1, 10, "frame_start");
        wait_busy(1'b0, 5000, "frame_done");
        @(negedge clk);
        chk("beat_count", 32'(beats - b0), 32'(v.exp_n));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("rdr_words", 32'(rdr_words), 32'(v.size) & 32'h1ff);
        chk("rdr_trunc", 32'(rdr_trunc), 32'(v.exp_trunc));
        chk("cs_idle", 32'(erx_cs), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int cs_cnt;
        int err_cnt;
        int t;
        bit bad;

        vecs[0] = '{3,   32'h0000_00A0, 1, 0, 0, 3,   1'b0};
        vecs[1] = '{3,   32'h0000_00A0, 2, 2, 5, 3,   1'b0};
        vecs[2] = '{400, 32'h1000_0000, 1, 0, 0, 376, 1'b1};
        vecs[3] = '{0,   32'h0000_0000, 1, 0, 0, 0,   1'b0};
        vecs[4] = '{1,   32'h0000_00B0, 3, 1, 2, 1,   1'b0};
        vecs[5] = '{376, 32'h2000_0000, 1, 0, 0, 376, 1'b0};

        // Reset with erx_ready held high
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", 32'(erx_cs), 32'd0);
        chk("rst_cmd", 32'(erx_cmd), 32'd0);
        chk("rst_valid", 32'(rdr_valid), 32'd0);
        chk("rst_last", 32'(rdr_last), 32'd0);
        chk("rst_data", rdr_data, 32'd0);
        chk("rst_words", 32'(rdr_words), 32'd0);
        chk("rst_trunc", 32'(rdr_trunc), 32'd0);
        chk("rst_err", 32'(rdr_err), 32'd0);
        chk("rst_busy_sync", 32'(rdr_busy), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (erx_cs || rdr_busy) bad = 1;
        end
        chk("post_reset_quiet", 32'(bad), 32'd0);

        for (int i = 0; i < 6; i++) run_frame(vecs[i]);

        // Frame notification while disarmed is dropped
        rdr_en = 1'b0;
        @(negedge clk);
        notify_req = 1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (erx_cs || rdr_busy) bad = 1;
        end
        chk("disarmed_drop", 32'(bad), 32'd0);
        rdr_en = 1'b1;

        // GETDATA never answered: timeout after 64 cycles of cs
        mute_data = 1;
        fr_size   = 3;
        resp_lat  = 1;
        @(negedge clk);
        notify_req = 1;
        for (t = 0; t < 50 && !(erx_cs && erx_cmd == 4'd2); t++) @(negedge clk);
        chk("getdata_issued", 32'(erx_cs && erx_cmd == 4'd2), 32'd1);
        cs_cnt  = 0;
        err_cnt = 0;
        for (t = 0; t < 300; t++) begin
            if (erx_cs) cs_cnt++;
            if (rdr_err) err_cnt++;
            if (!erx_cs && !rdr_busy && cs_cnt > 0) break;
            @(negedge clk);
        end
        chk("timeout_cs_cycles", 32'(cs_cnt), 32'd64);
        chk("timeout_err_pulse", 32'(err_cnt), 32'd1);
        chk("timeout_idle", 32'(rdr_busy), 32'd0);
        mute_data = 0;
        run_frame(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
